// File: rtl/keypad_press_emulator.sv
// Plays back one requested hex-key press against a column-scanning keypad controller:
// press bounce, solid hold, release bounce, then a guaranteed open gap.
module keypad_press_emulator #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned BOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [3:0] req_code,
  output logic       req_ready,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] BOUNCE_LD = CNT_W'(BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               BOUNCE_EN = (BOUNCE_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P_BOUNCE = 3'd1,
    HOLD     = 3'd2,
    R_BOUNCE = 3'd3,
    GAP      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             contact_q, contact_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             last_c;

  assign last_c = (cnt_q == CNT_ONE);

  // Next state; contact is computed for the cycle being entered so it leaves a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    contact_d = contact_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        contact_d = 1'b0;
        if (req_valid) begin
          code_d    = req_code;
          contact_d = 1'b1;
          if (BOUNCE_EN) begin
            state_d = P_BOUNCE;
            cnt_d   = BOUNCE_LD;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end
        end
      end
      P_BOUNCE: begin
        if (last_c) begin
          state_d   = HOLD;
          cnt_d     = HOLD_LD;
          contact_d = 1'b1;
        end else begin
          cnt_d     = cnt_q - CNT_ONE;
          contact_d = ~contact_q;
        end
      end
      HOLD: begin
        if (last_c) begin
          contact_d = 1'b0;
          if (BOUNCE_EN) begin
            state_d = R_BOUNCE;
            cnt_d   = BOUNCE_LD;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d     = cnt_q - CNT_ONE;
          contact_d = 1'b1;
        end
      end
      R_BOUNCE: begin
        if (last_c) begin
          state_d   = GAP;
          cnt_d     = GAP_LD;
          contact_d = 1'b0;
        end else begin
          cnt_d     = cnt_q - CNT_ONE;
          contact_d = ~contact_q;
        end
      end
      GAP: begin
        contact_d = 1'b0;
        if (last_c) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        contact_d = 1'b0;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      code_q    <= 4'h0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      contact_q <= contact_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Row is a pure combinational return of the selected column, gated by the contact flop.
  always_comb begin
    Row = 4'b0000;
    Row[code_q[3:2]] = contact_q & Col[code_q[1:0]];
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_keypad_press_emulator.sv
// Bench for keypad_press_emulator: fixed vectors, corner sequences and random traffic
// compared against a cycle-index reference model of the press timeline.
module tb_keypad_press_emulator;

  localparam int B     = 4;
  localparam int H     = 16;
  localparam int G     = 8;
  localparam int TOTAL = 2 * B + H + G;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic [3:0] req_code;
  logic       req_ready;
  logic [3:0] Col;
  logic [3:0] Row;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  // Reference model: position in the press timeline, counted from the accepting edge.
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_t    = 0;
  logic [3:0] m_code = 4'h0;

  typedef struct {
    logic [3:0] code;
    logic [3:0] col;
    logic [3:0] row;
  } vec_t;

  vec_t tbl [9];

  keypad_press_emulator #(
    .HOLD_CYCLES  (H),
    .BOUNCE_CYCLES(B),
    .GAP_CYCLES   (G),
    .CNT_W        (8)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_code (req_code),
    .req_ready(req_ready),
    .Col      (Col),
    .Row      (Row),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  function automatic bit contact_at(input int t);
    if (t <= B)          return (t % 2) == 1;
    else if (t <= B + H) return 1'b1;
    else if (t <= 2*B+H) return ((t - B - H) % 2) == 0;
    else                 return 1'b0;
  endfunction

  function automatic logic [3:0] exp_row();
    logic [3:0] r;
    r = 4'b0000;
    if (m_busy && contact_at(m_t) && Col[m_code[1:0]]) r[m_code[3:2]] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!m_busy && req_valid) begin
      m_busy = 1'b1;
      m_t    = 1;
      m_code = req_code;
      m_done = 1'b0;
    end else if (m_busy) begin
      m_t++;
      if (m_t > TOTAL) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #2;
    check("ready", 32'(req_ready), 32'(!m_busy));
    check("busy",  32'(busy),      32'(m_busy));
    check("done",  32'(done),      32'(m_done));
    check("row",   32'(Row),       32'(exp_row()));
  endtask

  task automatic drain(output int dones);
    int n;
    dones = 0;
    n = 0;
    while ((m_busy || m_done) && n < 100) begin
      step();
      if (done) dones++;
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, n, dn;
    logic [31:0] pat;

    tbl[0] = '{4'h6, 4'b0100, 4'b0010};
    tbl[1] = '{4'h6, 4'b0010, 4'b0000};
    tbl[2] = '{4'hF, 4'b1111, 4'b1000};
    tbl[3] = '{4'h0, 4'b0001, 4'b0001};
    tbl[4] = '{4'hA, 4'b0100, 4'b0100};
    tbl[5] = '{4'h5, 4'b0010, 4'b0010};
    tbl[6] = '{4'h9, 4'b1111, 4'b0100};
    tbl[7] = '{4'h3, 4'b0111, 4'b0000};
    tbl[8] = '{4'hC, 4'b0000, 4'b0000};

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_code  = 4'h0;
    Col       = 4'b1111;
    #12;
    check("rst_row",   32'(Row),       32'(0));
    check("rst_ready", 32'(req_ready), 32'(1));
    check("rst_busy",  32'(busy),      32'(0));
    check("rst_done",  32'(done),      32'(0));
    Col = 4'b0000;
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Code 6, Col walked one-hot during HOLD; measure busy length and done position.
    req_valid = 1'b1;
    req_code  = 4'h6;
    step();
    req_valid = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = k; end
      if (k >= B + 1 && k <= B + H)
        check("hold_row", 32'(Row), (k % 4 == 2) ? 32'(4'b0010) : 32'(0));
      Col = (k + 1 >= B + 1 && k + 1 <= B + H) ? 4'(1 << ((k + 1) % 4)) : 4'b0000;
      step();
    end
    check("busy_len", 32'(busy_cnt), 32'(TOTAL));
    check("done_cnt", 32'(done_cnt), 32'(1));
    check("done_at",  32'(done_at),  32'(TOTAL + 1));

    // Code F with Col held high: Row[3] traces the full bounce/hold/bounce/gap shape.
    pat = 32'b1010_1111_1111_1111_1111_0101_0000_0000;
    Col = 4'b1111;
    req_valid = 1'b1;
    req_code  = 4'hF;
    step();
    req_valid = 1'b0;
    for (int t = 1; t <= TOTAL; t++) begin
      check("f_row", 32'(Row), 32'({pat[32 - t], 3'b000}));
      step();
    end
    check("f_done", 32'(done), 32'(1));
    drain(dn);

    // req_valid held across two codes: the second is taken in the done cycle.
    req_valid = 1'b1;
    req_code  = 4'h0;
    step();
    req_code = 4'hA;
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    check("b2b_done_time", 32'(n), 32'(TOTAL));
    step();
    req_valid = 1'b0;
    check("b2b_accept", 32'(busy), 32'(1));
    check("b2b_row",    32'(Row),  32'(4'b0100));
    drain(dn);
    check("b2b_dones", 32'(dn), 32'(1));

    // One-cycle request while busy must be dropped.
    req_valid = 1'b1;
    req_code  = 4'h3;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    req_valid = 1'b1;
    req_code  = 4'hC;
    step();
    req_valid = 1'b0;
    check("ign_ready", 32'(req_ready), 32'(0));
    repeat (B) step();
    check("ign_row", 32'(Row), 32'(4'b0001));
    drain(dn);
    check("ign_dones", 32'(dn), 32'(1));
    repeat (10) step();

    // Asynchronous reset in the middle of HOLD.
    Col = 4'b0010;
    req_valid = 1'b1;
    req_code  = 4'h5;
    step();
    req_valid = 1'b0;
    repeat (B + 3) step();
    check("rst_pre_row", 32'(Row), 32'(4'b0010));
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_row",   32'(Row),       32'(0));
    check("arst_ready", 32'(req_ready), 32'(1));
    check("arst_busy",  32'(busy),      32'(0));
    check("arst_done",  32'(done),      32'(0));
    @(negedge clock);
    reset_n = 1'b1;
    m_busy = 1'b0; m_done = 1'b0; m_t = 0;
    repeat (5) step();

    // Fixed vectors: Row sampled mid-HOLD for a given code/Col pair.
    foreach (tbl[i]) begin
      Col = 4'b0000;
      req_valid = 1'b1;
      req_code  = tbl[i].code;
      step();
      req_valid = 1'b0;
      repeat (B + 4) step();
      Col = tbl[i].col;
      #1;
      check("tbl_row", 32'(Row), 32'(tbl[i].row));
      drain(dn);
    end

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_code  = 4'($urandom);
      Col       = 4'($urandom);
      step();
    end
    req_valid = 1'b0;
    drain(dn);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
